barrett_reduce_pipe: RTL and testbench

BARRETT_REDUCE_PIPE -- requirements
Module: barrett_reduce_pipe

---
 rtl/barrett_reduce_pipe.sv | 166 ++++++++++++++++
 tb/tb_barrett_reduce_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/barrett_reduce_pipe.sv
// rtl/barrett_reduce_pipe.sv - 3-stage pipelined Barrett reduction of X mod PRIME with valid/ready and tag sideband
// Optional macro BARRETT_RANGE_CHECK_EN flags operands >= PRIME*PRIME on out_range_err.
module barrett_reduce_pipe #(
  parameter int unsigned PRIME  = 3329,
  parameter int unsigned MOD_W  = 12,
  parameter int unsigned DATA_W = 2 * MOD_W,
  parameter int unsigned MU     = (1 << (2 * MOD_W)) / PRIME,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MOD_W-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_range_err
);

  localparam int unsigned Q1_W   = DATA_W - MOD_W + 1;
  localparam int unsigned MU_W   = MOD_W + 1;
  localparam int unsigned P1_W   = Q1_W + MU_W;
  localparam int unsigned Q2_W   = P1_W - MOD_W - 1;
  localparam int unsigned QP_W   = Q2_W + MOD_W;
  localparam int unsigned DIFF_W = (DATA_W > QP_W) ? DATA_W : QP_W;
  localparam int unsigned R_W    = MOD_W + 2;

  localparam logic [MU_W-1:0]  MU_C    = MU_W'(MU);
  localparam logic [MOD_W-1:0] PRIME_C = MOD_W'(PRIME);
  localparam logic [R_W-1:0]   P1_R    = R_W'(PRIME);
  localparam logic [R_W-1:0]   P2_R    = R_W'(2 * PRIME);

  logic              en1, en2, en3;
  logic [Q1_W-1:0]   q1;
  logic [Q2_W-1:0]   q2;
  logic [R_W-1:0]    corr;

  logic              v1_q, v1_d;
  logic [DATA_W-1:0] x1_q, x1_d;
  logic [P1_W-1:0]   p1_q, p1_d;
  logic [TAG_W-1:0]  tag1_q, tag1_d;

  logic              v2_q, v2_d;
  logic [R_W-1:0]    r2_q, r2_d;
  logic [TAG_W-1:0]  tag2_q, tag2_d;

  logic              v3_q, v3_d;
  logic [MOD_W-1:0]  d3_q, d3_d;
  logic [TAG_W-1:0]  tag3_q, tag3_d;

  assign in_ready  = !(v3_q && !out_ready);
  assign out_valid = v3_q;
  assign out_data  = d3_q;
  assign out_tag   = tag3_q;

  always_comb begin
    // A stage may load whenever it is empty or its successor is moving, which collapses bubbles.
    en3 = !v3_q || out_ready;
    en2 = !v2_q || en3;
    en1 = !v1_q || en2;

    q1 = Q1_W'(in_data >> (MOD_W - 1));
    q2 = Q2_W'(p1_q >> (MOD_W + 1));

    if (r2_q >= P2_R) begin
      corr = r2_q - P2_R;
    end else if (r2_q >= P1_R) begin
      corr = r2_q - P1_R;
    end else begin
      corr = r2_q;
    end

    v1_d   = v1_q;
    x1_d   = x1_q;
    p1_d   = p1_q;
    tag1_d = tag1_q;
    if (en1) begin
      v1_d   = in_valid && in_ready;
      x1_d   = in_data;
      p1_d   = P1_W'(q1) * P1_W'(MU_C);
      tag1_d = in_tag;
    end

    v2_d   = v2_q;
    r2_d   = r2_q;
    tag2_d = tag2_q;
    if (en2) begin
      v2_d   = v1_q;
      // The true remainder is below 3*PRIME, so the low R_W bits of the wide difference are exact.
      r2_d   = R_W'(DIFF_W'(x1_q) - DIFF_W'(q2) * DIFF_W'(PRIME_C));
      tag2_d = tag1_q;
    end

    v3_d   = v3_q;
    d3_d   = d3_q;
    tag3_d = tag3_q;
    if (en3) begin
      v3_d   = v2_q;
      d3_d   = MOD_W'(corr);
      tag3_d = tag2_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q   <= 1'b0;
      x1_q   <= '0;
      p1_q   <= '0;
      tag1_q <= '0;
      v2_q   <= 1'b0;
      r2_q   <= '0;
      tag2_q <= '0;
      v3_q   <= 1'b0;
      d3_q   <= '0;
      tag3_q <= '0;
    end else begin
      v1_q   <= v1_d;
      x1_q   <= x1_d;
      p1_q   <= p1_d;
      tag1_q <= tag1_d;
      v2_q   <= v2_d;
      r2_q   <= r2_d;
      tag2_q <= tag2_d;
      v3_q   <= v3_d;
      d3_q   <= d3_d;
      tag3_q <= tag3_d;
    end
  end

`ifdef BARRETT_RANGE_CHECK_EN
  localparam logic [DATA_W:0] PSQ_C = (DATA_W + 1)'(PRIME * PRIME);

  logic err1_q, err1_d;
  logic err2_q, err2_d;
  logic err3_q, err3_d;

  always_comb begin
    err1_d = err1_q;
    err2_d = err2_q;
    err3_d = err3_q;
    if (en1) err1_d = ({1'b0, in_data} >= PSQ_C);
    if (en2) err2_d = err1_q;
    if (en3) err3_d = err2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err1_q <= 1'b0;
      err2_q <= 1'b0;
      err3_q <= 1'b0;
    end else begin
      err1_q <= err1_d;
      err2_q <= err2_d;
      err3_q <= err3_d;
    end
  end

  assign out_range_err = err3_q;
`else
  assign out_range_err = 1'b0;
`endif

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// tb/tb_barrett_reduce_pipe.sv - self-checking bench for barrett_reduce_pipe
module tb_barrett_reduce_pipe;

  localparam int unsigned PRIME = 3329;
  localparam int unsigned PSQ   = 11082241;
`ifdef BARRETT_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [3:0]  out_tag;
  logic        out_range_err;

  always #5 clk = ~clk;

  barrett_reduce_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_tag       (out_tag),
    .out_range_err (out_range_err)
  );

  typedef struct {
    logic [23:0] x;
    logic [3:0]  tag;
    logic [11:0] exp;
    logic        err;
  } exp_t;

  typedef struct {
    logic [23:0] x;
    logic [3:0]  tag;
    logic [11:0] exp;
    bit          dom;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_err(input logic [23:0] x);
    return RC_EN && (32'(x) >= PSQ);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_output_expected", longint'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          if (32'(e.x) < PSQ) check("sb_data", out_data, e.exp);
          check("sb_tag", out_tag, e.tag);
          check("sb_range_err", out_range_err, e.err);
        end
      end
      if (in_valid && in_ready) begin
        e.x   = in_data;
        e.tag = in_tag;
        e.exp = 12'(32'(in_data) % PRIME);
        e.err = exp_err(in_data);
        sb.push_back(e);
      end
    end
  end

  // Entered and left at 1 time unit after a rising edge.
  task automatic drive_cycle(input logic v, input logic [23:0] x, input logic [3:0] t,
                             input logic ordy, output logic fired);
    in_valid  = v;
    in_data   = x;
    in_tag    = t;
    out_ready = ordy;
    @(negedge clk);
    fired = v && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic f;
    for (int i = 0; i < 60 && sb.size() > 0; i++) drive_cycle(1'b0, 24'd0, 4'd0, 1'b1, f);
    drive_cycle(1'b0, 24'd0, 4'd0, 1'b1, f);
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic        f;
    logic        pend;
    logic [23:0] rx;
    logic [3:0]  rtag;
    logic [11:0] held;
    int          cnt;
    int          sel;

    tbl[0] = '{24'd0,        4'd1, 12'd0,    1'b1};
    tbl[1] = '{24'd3328,     4'd2, 12'd3328, 1'b1};
    tbl[2] = '{24'd3329,     4'd3, 12'd0,    1'b1};
    tbl[3] = '{24'd12345,    4'd4, 12'd2358, 1'b1};
    tbl[4] = '{24'd11075584, 4'd5, 12'd1,    1'b1};
    tbl[5] = '{24'd11082240, 4'd6, 12'd3328, 1'b1};
    tbl[6] = '{24'd11082241, 4'd7, 12'd0,    1'b0};
    tbl[7] = '{24'd6658,     4'd8, 12'd0,    1'b1};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_range_err", out_range_err, 0);
    check("reset_in_ready", in_ready, 1);
    rst = 1'b1;

    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        drive_cycle(1'b1, tbl[k].x, tbl[k].tag, 1'b1, f);
        check("tbl_accept", f, 1);
      end else begin
        drive_cycle(1'b0, 24'd0, 4'd0, 1'b1, f);
      end
      if (k < 2) check("tbl_latency_idle", out_valid, 0);
      else begin
        check("tbl_out_valid", out_valid, 1);
        if (tbl[k-2].dom) check("tbl_out_data", out_data, tbl[k-2].exp);
        check("tbl_out_tag", out_tag, tbl[k-2].tag);
        check("tbl_range_err", out_range_err, exp_err(tbl[k-2].x));
      end
    end
    drain();

    cnt = 0;
    for (int i = 0; i < 10 && cnt < 3; i++) begin
      drive_cycle(1'b1, 24'(1000 + cnt * 777), 4'(8 + cnt), 1'b0, f);
      if (f) cnt++;
    end
    check("stall_fill_count", cnt, 3);
    check("stall_in_ready", in_ready, 0);
    check("stall_first_data", out_data, 1000);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 24'd4242, 4'd11, 1'b0, f);
      check("stall_no_accept", f, 0);
      check("stall_valid_held", out_valid, 1);
      check("stall_data_held", out_data, held);
      check("stall_tag_held", out_tag, 8);
    end
    drive_cycle(1'b1, 24'd4242, 4'd11, 1'b1, f);
    check("accept_on_release", f, 1);
    check("release_next_valid", out_valid, 1);
    check("release_next_data", out_data, 1777);
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 24'd0, 4'd0, 1'b1, f);
      check("release_stream_valid", out_valid, 1);
    end
    drain();

    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 24'(5000 + 1000 * i), 4'(1 + i), 1'b1, f);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_data", out_data, 0);
    check("midreset_out_tag", out_tag, 0);
    check("midreset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_cycle(1'b1, 24'd6658, 4'd5, 1'b1, f);
    check("postreset_accept", f, 1);
    check("postreset_idle0", out_valid, 0);
    drive_cycle(1'b0, 24'd0, 4'd0, 1'b1, f);
    check("postreset_idle1", out_valid, 0);
    drive_cycle(1'b0, 24'd0, 4'd0, 1'b1, f);
    check("postreset_valid", out_valid, 1);
    check("postreset_data", out_data, 0);
    check("postreset_tag", out_tag, 5);
    drain();

    pend = 1'b0; rx = '0; rtag = '0;
    for (int c = 0; c < 20000; c++) begin
      if (!pend && $urandom_range(3, 0) != 0) begin
        sel = int'($urandom_range(7, 0));
        case (sel)
          0:       rx = 24'(PSQ - 1);
          1:       rx = 24'($urandom_range(3328, 0) * PRIME);
          2:       rx = 24'($urandom_range(3329, 1) * PRIME - 1);
          default: rx = 24'($urandom_range(PSQ - 1, 0));
        endcase
        rtag = rtag + 4'd1;
        pend = 1'b1;
      end
      drive_cycle(pend, rx, rtag, $urandom_range(3, 0) != 0, f);
      if (f) pend = 1'b0;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
